// File: rtl/tpu_sched.sv
// Matrix-multiply sequencer: CLEAR -> LOAD -> RUN -> READ -> DONE, one multiply per start.
// Optional perf_cycles counter is built only when TPU_SCHED_PERF_EN is defined.
module tpu_sched #(
  parameter int DIM     = 8,
  parameter int RUN_CYC = 3*DIM-2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    ld_req,
  output logic [$clog2(DIM)-1:0]  ld_row,
  input  logic                    ld_ack,
  output logic                    mem_wren,
  output logic                    mem_en,
  output logic [$clog2(DIM)-1:0]  mem_row,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    c_valid,
  output logic [$clog2(DIM)-1:0]  c_row,
  input  logic                    c_ready,
  output logic [15:0]             perf_cycles
);
  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(RUN_CYC+1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DIM-1);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYC-1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_READ, S_DONE
  } state_t;

  state_t        state, nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_CLEAR;
      S_CLEAR: nxt = S_LOAD;
      S_LOAD:  if (ld_ack && row == ROW_LAST) nxt = S_RUN;
      S_RUN:   if (run_cnt == RUN_LAST) nxt = S_READ;
      S_READ:  if (c_ready && row == ROW_LAST) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Row counter is shared by LOAD and READ; it wraps to 0 after the last row of each.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      run_cnt <= '0;
    end else begin
      case (state)
        S_CLEAR: row <= '0;
        S_LOAD: if (ld_ack) begin
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
          if (row == ROW_LAST) run_cnt <= '0;
        end
        S_RUN:  run_cnt <= run_cnt + 1'b1;
        S_READ: if (c_ready) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = 1'b0;
    ld_req   = 1'b0;
    ld_row   = '0;
    mem_wren = 1'b0;
    mem_en   = 1'b0;
    mem_row  = '0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    c_valid  = 1'b0;
    c_row    = '0;
    case (state)
      S_CLEAR: mac_clr = 1'b1;
      S_LOAD: begin
        // Write strobe follows the host ack combinationally so a row lands the cycle it is presented.
        ld_req   = 1'b1;
        ld_row   = row;
        mem_row  = row;
        mem_wren = ld_ack;
        mem_en   = ld_ack;
      end
      S_RUN: begin
        mem_en = 1'b1;
        mac_en = 1'b1;
      end
      S_READ: begin
        c_valid = 1'b1;
        c_row   = row;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef TPU_SCHED_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          perf_q <= '0;
    else if (state == S_IDLE && start) perf_q <= '0;
    else if (busy && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: doc/tpu_sched.md
# tpu_sched

Top-level sequencer for the systolic-array matrix-multiply path. It runs one full DIM×DIM multiply per `start`: accumulator clear, row-by-row load of the A/B operand memories through a host handshake, the skewed compute window, and row-by-row readout of C. It sits between the host interface and the memA/memB/tpumac array and owns every enable, write-enable and row index those blocks see.

## Interface
Parameters:
- `DIM`, 8: array dimension (rows and columns). Must be ≥ 2.
- `RUN_CYC`, 3*DIM-2: length of the compute window in cycles (skew fill plus drain).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-high.
- `start`  in  1  begin a multiply. Sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `ld_req`  out  1  request the host to present operand row `ld_row`.
- `ld_row`  out  $clog2(DIM)  operand row index.
- `ld_ack`  in  1  host presents A/B row data this cycle.
- `mem_wren`  out  1  write strobe to memA/memB (WrEn).
- `mem_en`  out  1  shift enable to memA/memB (en).
- `mem_row`  out  $clog2(DIM)  row index to memA/memB (equal to `ld_row`).
- `mac_clr`  out  1  clear all tpumac accumulators.
- `mac_en`  out  1  tpumac accumulate enable.
- `c_valid`  out  1  result row `c_row` is valid.
- `c_row`  out  $clog2(DIM)  result row index.
- `c_ready`  in  1  consumer accepts the result row.
- `perf_cycles`  out  16  cycles from CLEAR to DONE inclusive (see Configuration).

## Operation
- States: IDLE → CLEAR → LOAD → RUN → READ → DONE → IDLE. State, row counter (`$clog2(DIM)` bits) and run counter (`$clog2(RUN_CYC+1)` bits) are registers.
- IDLE: all outputs 0. `start`=1 → CLEAR.
- CLEAR: exactly 1 cycle. `mac_clr`=1. Row counter cleared. → LOAD.
- LOAD: `ld_req`=1, `ld_row`=`mem_row`=row counter.
  - `mem_wren` = `mem_en` = `ld_req & ld_ack`. These are the only combinational paths from an input to an output.
  - On ack, the row counter increments. Ack on row DIM-1 → RUN, row counter cleared, run counter cleared.
  - `ld_ack`=0 stalls: the request and row are held.
- RUN: `mem_en`=1, `mac_en`=1 for exactly RUN_CYC cycles. The run counter increments each cycle. Count RUN_CYC-1 → READ.
- READ: `c_valid`=1, `c_row`=row counter.
  - `c_valid & c_ready` advances the row. Accepted row DIM-1 → DONE.
  - `c_ready`=0 holds `c_valid` and `c_row` stable.
- DONE: `done`=1 for 1 cycle. → IDLE.
- `start` is ignored while `busy`=1. `start` held high continuously produces back-to-back multiplies, each passing through IDLE for one cycle.
- `ld_ack` outside LOAD and `c_ready` outside READ are ignored.

## Timing
- Reset value of every output and every register: 0. State = IDLE.
- `rst` mid-operation aborts immediately to IDLE. No partial `done` is generated and the next `start` restarts from CLEAR.
- Latency with `ld_ack`=`c_ready`=1 throughout, `start` sampled at cycle 0:
  - CLEAR at cycle 1.
  - LOAD for cycles 2..DIM+1.
  - RUN for cycles DIM+2..4*DIM-1.
  - READ for cycles 4*DIM..5*DIM-1.
  - DONE at cycle 5*DIM.
  - For DIM=8, `done` is at cycle 40.
- Each LOAD or READ stall cycle adds exactly one cycle to the total.
- All outputs except `mem_wren`/`mem_en` in LOAD are decoded from registers only.

## Configuration
- `TPU_SCHED_PERF_EN` defined:
  - `perf_cycles` counts every cycle with `busy`=1. It clears on entry to CLEAR and saturates at 16'hFFFF.
  - The value holds after DONE until the next CLEAR.
  - Reset value is 0.
- Not defined: `perf_cycles` is tied to 0 and no counter logic is built.

## Test plan
- DIM=8, `start` pulse, `ld_ack`=`c_ready`=1:
  - `busy` is high for cycles 1..40 and `done` is high only in cycle 40.
  - `mac_clr` is high in cycle 1 only.
  - `mem_wren` is high for 8 cycles with `mem_row` 0..7.
  - `mac_en` is high for 22 cycles.
  - `c_row` runs 0..7.
- LOAD stall: `ld_ack` low for 3 cycles at row 4.
  - `ld_row` holds at 4.
  - `mem_wren` is 0 during the stall.
  - `done` moves to cycle 43.
  - With `TPU_SCHED_PERF_EN` defined, `perf_cycles`=43.
- READ backpressure: `c_ready` toggles 1/0 each cycle.
  - Each `c_row` is held until accepted.
  - All rows 0..7 are accepted exactly once.
  - `done` follows the acceptance of row 7.
- `start` asserted during RUN is ignored; `start` held high across DONE starts a new CLEAR 2 cycles after `done`.
- `rst` pulsed in RUN at run count 10:
  - All outputs drop to 0 asynchronously and no `done` pulse occurs.
  - A following `start` gives the full 40-cycle sequence.
- Macro undefined: `perf_cycles` stays 0 through the full sequence.
